input_debounce: RTL and testbench

- Upstream conditioning stage for edge_detect: synchronises an asynchronous, possibly bouncy data_in into the clk domain.
- Qualifies the synchronised level as stable for DEB_CYCLES consecutive cycles and only then forwards it on data_out.
- data_out drives edge_detect.data_in directly, so edge_detect sees exactly one clean transition per real input transition.
- Rejected transitions (bounces) are counted for diagnostics.

---
 rtl/edge_pkg.sv | 36 +++
 rtl/input_debounce_if.sv | 34 +++
 rtl/sync_chain.sv | 36 +++
 rtl/input_debounce.sv | 122 ++++++++++++
 tb/tb_input_debounce.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/edge_pkg.sv
// ---------------------------------------------------------------------------
// edge_pkg
// Shared definitions for the input conditioning stages in front of
// edge_detect.
//   state_t          : debounce FSM states (STABLE, QUALIFY)
//   DEB_CYCLES_DEF   : default qualification length in cycles
//   SYNC_STAGES_DEF  : default synchroniser depth
//   cnt_width(n)     : ceil(log2(n)), used to size the qualify counter so it
//                      can hold the value DEB_CYCLES
// ---------------------------------------------------------------------------
package edge_pkg;

    typedef enum logic {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } state_t;

    localparam int DEB_CYCLES_DEF  = 4;
    localparam int SYNC_STAGES_DEF = 2;

    // Smallest w with 2**w >= n. Loop bound is fixed so it elaborates cleanly.
    function automatic int cnt_width(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/input_debounce_if.sv
// ---------------------------------------------------------------------------
// input_debounce_if
// Signal bundle between a raw-input source and the debouncer.
//   en         : qualification enable (source -> debouncer)
//   data_in    : raw asynchronous level (source -> debouncer)
//   data_out   : debounced, synchronised level (debouncer -> consumer)
//   busy       : candidate transition under qualification
//   glitch_cnt : saturating count of rejected transitions
//   state_dbg  : current FSM state, exported for observation
// There is no handshake: data_in is a level sampled every cycle and all
// outputs are registered levels valid every cycle after reset.
// ---------------------------------------------------------------------------
interface input_debounce_if
    import edge_pkg::*;
#(
    parameter int GLITCH_W = 8
);
    logic                en;
    logic                data_in;
    logic                data_out;
    logic                busy;
    logic [GLITCH_W-1:0] glitch_cnt;
    state_t              state_dbg;

    modport master (
        output en, data_in,
        input  data_out, busy, glitch_cnt, state_dbg
    );

    modport slave (
        input  en, data_in,
        output data_out, busy, glitch_cnt, state_dbg
    );
endinterface

// File: rtl/sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
// Multi-flop synchroniser for one asynchronous bit. Reusable for any raw
// input feeding edge_detect.
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset, loads RST_VAL into every stage
//   init_n : synchronous active-low re-initialise, same effect at the edge
//   d      : asynchronous input
//   q      : synchronised output (last stage)
// ---------------------------------------------------------------------------
module sync_chain #(
    parameter int SYNC_STAGES = 2,
    parameter bit RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic init_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= {SYNC_STAGES{RST_VAL}};
        end else if (!init_n) begin
            r_chain <= {SYNC_STAGES{RST_VAL}};
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// ---------------------------------------------------------------------------
// input_debounce
// Synchronises a bouncy asynchronous level and forwards it only after it has
// differed from the current output for DEB_CYCLES consecutive cycles, so the
// downstream edge_detect sees one clean transition per real transition.
// Aborted qualifications (bounces) are counted in a saturating counter.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   init_n : synchronous active-low re-initialise (priority over en)
//   bus    : slave side of input_debounce_if (en, data_in in; data_out,
//            busy, glitch_cnt, state_dbg out)
// All outputs are registered; there is no combinational path from data_in.
// ---------------------------------------------------------------------------
module input_debounce
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter bit RST_VAL     = 1'b0,
    parameter int GLITCH_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_n,
    input_debounce_if.slave   bus
);

    localparam int               CNT_W = cnt_width(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEB_CYCLES - 1);

    logic                w_sync_q;
    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_out;
    logic                w_out_nxt;
    logic [GLITCH_W-1:0] r_glitch;
    logic [GLITCH_W-1:0] w_glitch_nxt;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (RST_VAL)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .init_n (init_n),
        .d      (bus.data_in),
        .q      (w_sync_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= STABLE;
            r_cnt    <= '0;
            r_out    <= RST_VAL;
            r_glitch <= '0;
        end else if (!init_n) begin
            r_state  <= STABLE;
            r_cnt    <= '0;
            r_out    <= RST_VAL;
            r_glitch <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_out    <= w_out_nxt;
            r_glitch <= w_glitch_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_out_nxt    = r_out;
        w_glitch_nxt = r_glitch;

        if (!bus.en) begin
            // Abort silently: a disabled qualification is not a bounce.
            w_state_nxt = STABLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                STABLE: begin
                    if (w_sync_q != r_out) begin
                        if (DEB_CYCLES == 1) begin
                            w_out_nxt = w_sync_q;
                        end else begin
                            // The first differing cycle already counts as one.
                            w_state_nxt = QUALIFY;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                QUALIFY: begin
                    if (w_sync_q == r_out) begin
                        w_state_nxt = STABLE;
                        w_cnt_nxt   = '0;
                        if (r_glitch != {GLITCH_W{1'b1}}) begin
                            w_glitch_nxt = r_glitch + GLITCH_W'(1);
                        end
                    end else if (r_cnt == LAST) begin
                        w_state_nxt = STABLE;
                        w_cnt_nxt   = '0;
                        w_out_nxt   = w_sync_q;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign bus.data_out   = r_out;
    assign bus.busy       = (r_state == QUALIFY);
    assign bus.glitch_cnt = r_glitch;
    assign bus.state_dbg  = r_state;

endmodule

// File: tb/tb_input_debounce.sv
// ---------------------------------------------------------------------------
// tb_input_debounce
// Directed bench for input_debounce: a default instance (SYNC_STAGES=2,
// DEB_CYCLES=4) driven from a per-edge vector table, plus a second instance
// (SYNC_STAGES=3, DEB_CYCLES=1) with its own short table. Each table record
// holds the inputs applied before one rising edge and the outputs expected
// just after it.
// ---------------------------------------------------------------------------
module tb_input_debounce;
    import edge_pkg::*;

    typedef struct {
        logic       init_n;
        logic       en;
        logic       din;
        logic       exp_out;
        logic       exp_busy;
        logic [7:0] exp_glitch;
    } vec_t;

    typedef struct {
        logic din;
        logic exp_out;
    } vec2_t;

    logic clk;
    logic rst_n;
    logic init_n;
    int   n_vec;
    int   n_err;
    vec_t  vecs[$];
    vec2_t vecs2[$];

    input_debounce_if #(.GLITCH_W(8)) bus  ();
    input_debounce_if #(.GLITCH_W(8)) bus2 ();

    input_debounce #(
        .SYNC_STAGES (2),
        .DEB_CYCLES  (4),
        .RST_VAL     (1'b0),
        .GLITCH_W    (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .init_n (init_n),
        .bus    (bus)
    );

    input_debounce #(
        .SYNC_STAGES (3),
        .DEB_CYCLES  (1),
        .RST_VAL     (1'b0),
        .GLITCH_W    (8)
    ) dut_p (
        .clk    (clk),
        .rst_n  (rst_n),
        .init_n (init_n),
        .bus    (bus2)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic ini, input logic e, input logic d,
                                input logic eo, input logic eb, input logic [7:0] eg);
        vec_t v;
        v.init_n = ini; v.en = e; v.din = d;
        v.exp_out = eo; v.exp_busy = eb; v.exp_glitch = eg;
        vecs.push_back(v);
    endfunction

    function automatic void add2(input logic d, input logic eo);
        vec2_t v;
        v.din = d; v.exp_out = eo;
        vecs2.push_back(v);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        init_n      = v.init_n;
        bus.en      = v.en;
        bus.data_in = v.din;
        @(posedge clk);
        #1;
        chk({tag, ".data_out"},   32'(bus.data_out),   32'(v.exp_out));
        chk({tag, ".busy"},       32'(bus.busy),       32'(v.exp_busy));
        chk({tag, ".glitch_cnt"}, 32'(bus.glitch_cnt), 32'(v.exp_glitch));
    endtask

    task automatic drive(input logic d);
        @(negedge clk);
        bus.data_in = d;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vec_t v;
        n_vec = 0;
        n_err = 0;

        // Idle after reset
        for (int i = 0; i < 10; i++) add(1, 1, 0, 0, 0, 0);
        // Clean rise: busy over edges 3..5, data_out at edge 6
        add(1,1,1, 0,0,0); add(1,1,1, 0,0,0); add(1,1,1, 0,1,0);
        add(1,1,1, 0,1,0); add(1,1,1, 0,1,0); add(1,1,1, 1,0,0);
        // Clean fall: 6 edges later
        add(1,1,0, 1,0,0); add(1,1,0, 1,0,0); add(1,1,0, 1,1,0);
        add(1,1,0, 1,1,0); add(1,1,0, 1,1,0); add(1,1,0, 0,0,0);
        add(1,1,0, 0,0,0);
        // Two-cycle bounce rejected
        add(1,1,1, 0,0,0); add(1,1,1, 0,0,0); add(1,1,0, 0,1,0);
        add(1,1,0, 0,1,0); add(1,1,0, 0,0,1); add(1,1,0, 0,0,1);
        // Bounce 1,0,1,0 then settle at 1: two aborted runs, one rise
        add(1,1,1, 0,0,1); add(1,1,0, 0,0,1); add(1,1,1, 0,1,1);
        add(1,1,0, 0,0,2); add(1,1,1, 0,1,2); add(1,1,1, 0,0,3);
        add(1,1,1, 0,1,3); add(1,1,1, 0,1,3); add(1,1,1, 0,1,3);
        add(1,1,1, 1,0,3); add(1,1,1, 1,0,3);
        // en low mid-qualification: busy drops, output frozen, no glitch
        add(1,1,0, 1,0,3); add(1,1,0, 1,0,3); add(1,1,0, 1,1,3);
        add(1,0,0, 1,0,3); add(1,0,0, 1,0,3); add(1,0,0, 1,0,3);
        add(1,0,0, 1,0,3); add(1,0,1, 1,0,3); add(1,0,1, 1,0,3);
        add(1,1,1, 1,0,3); add(1,1,1, 1,0,3);
        // init_n (with en low) while data_out=1, then re-qualify held 1
        add(0,0,1, 0,0,0); add(1,1,1, 0,0,0); add(1,1,1, 0,0,0);
        add(1,1,1, 0,1,0); add(1,1,1, 0,1,0); add(1,1,1, 0,1,0);
        add(1,1,1, 1,0,0); add(1,1,1, 1,0,0);

        // DEB_CYCLES=1, SYNC_STAGES=3: change at edge 4, one-cycle pulse passes
        add2(1,0); add2(1,0); add2(1,0); add2(1,1); add2(0,1);
        add2(1,1); add2(1,1); add2(1,0); add2(1,1); add2(1,1);

        // ---- reset ----
        rst_n        = 1'b0;
        init_n       = 1'b1;
        bus.en       = 1'b1;
        bus.data_in  = 1'b0;
        bus2.en      = 1'b1;
        bus2.data_in = 1'b0;
        #1;
        chk("rst.data_out",   32'(bus.data_out),   32'd0);
        chk("rst.busy",       32'(bus.busy),       32'd0);
        chk("rst.glitch_cnt", 32'(bus.glitch_cnt), 32'd0);
        chk("rst.p_data_out", 32'(bus2.data_out),  32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold.data_out", 32'(bus.data_out), 32'd0);
        chk("rst_hold.busy",     32'(bus.busy),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- parameter variant ----
        for (int i = 0; i < vecs2.size(); i++) begin
            @(negedge clk);
            bus2.data_in = vecs2[i].din;
            @(posedge clk);
            #1;
            chk($sformatf("p%0d.data_out", i), 32'(bus2.data_out), 32'(vecs2[i].exp_out));
            chk($sformatf("p%0d.busy", i),     32'(bus2.busy),     32'd0);
        end
        chk("p.glitch_cnt", 32'(bus2.glitch_cnt), 32'd0);

        // ---- main table ----
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("v%0d", i));
        end

        // ---- asynchronous reset mid-qualification (data_out is 1 here) ----
        v.init_n = 1; v.en = 1; v.din = 0; v.exp_out = 1; v.exp_glitch = 0;
        v.exp_busy = 0; step(v, "mq0");
        step(v, "mq1");
        v.exp_busy = 1; step(v, "mq2");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mq_rst.data_out", 32'(bus.data_out), 32'd0);
        chk("mq_rst.busy",     32'(bus.busy),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- glitch counter saturation: 300 two-cycle bounces ----
        for (int it = 0; it < 300; it++) begin
            drive(1'b1); drive(1'b1);
            drive(1'b0); drive(1'b0); drive(1'b0); drive(1'b0);
            if (it == 0 || it == 253 || it == 254 || it == 299) begin
                chk($sformatf("sat%0d.glitch_cnt", it), 32'(bus.glitch_cnt),
                    (it + 1 > 255) ? 32'd255 : 32'(it + 1));
            end
            chk($sformatf("sat%0d.data_out", it), 32'(bus.data_out), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
